// File: rtl/acc_seq_ctrl.sv
// rtl/acc_seq_ctrl.sv - multi-cycle fetch/mem/writeback sequencer for the accumulator core
module acc_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      instr,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             acc_zero,
    output logic             write_acc,
    output logic             add_op,
    output logic             write_mem,
    output logic             branch_op,
    output logic             pc_en,
    output logic             pc_sel_branch,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_BRZ   = 2'b11;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] op;

    logic imem_req_q, dmem_req_q, dmem_we_q, pc_en_q;
    logic write_acc_q, add_op_q, branch_op_q, busy_q, halted_q;

    // Only the opcode field matters to the sequencer; the rest belongs to the datapath.
    logic instr_unused;
    assign instr_unused = ^instr[31:2];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
            S_DECODE: state_nxt = (op == OP_BRZ) ? S_WB : S_MEM;
            S_MEM:    if (dmem_ack) state_nxt = S_WB;
            S_WB:     state_nxt = halt_req ? S_HALT : S_FETCH;
            S_HALT:   if (start) state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Per-state outputs are registered from the next state so they are valid
    // for the whole cycle spent in that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            op          <= OP_LOAD;
            retired     <= '0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            pc_en_q     <= 1'b0;
            write_acc_q <= 1'b0;
            add_op_q    <= 1'b0;
            branch_op_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && imem_ack)
                op <= instr[1:0];
            if (state == S_WB)
                retired <= retired + 1'b1;
            imem_req_q  <= (state_nxt == S_FETCH);
            dmem_req_q  <= (state_nxt == S_MEM);
            dmem_we_q   <= (state_nxt == S_MEM) && (op == OP_STORE);
            pc_en_q     <= (state_nxt == S_WB);
            write_acc_q <= (state_nxt == S_WB) && (op == OP_LOAD || op == OP_ADD);
            add_op_q    <= (state_nxt == S_WB) && (op == OP_ADD);
            branch_op_q <= (state_nxt == S_WB) && (op == OP_BRZ);
            busy_q      <= (state_nxt != S_IDLE) && (state_nxt != S_HALT);
            halted_q    <= (state_nxt == S_HALT);
        end
    end

    assign imem_req      = imem_req_q;
    assign ir_load       = imem_req_q & imem_ack;
    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign write_mem     = dmem_we_q & dmem_ack;
    assign pc_en         = pc_en_q;
    assign write_acc     = write_acc_q;
    assign add_op        = add_op_q;
    assign branch_op     = branch_op_q;
    assign pc_sel_branch = branch_op_q & acc_zero;
    assign busy          = busy_q;
    assign halted        = halted_q;

endmodule
